// File: rtl/crc_arb_pkg.sv
// Shared types and defaults for crc_arbiter: FSM state enum and width/timeout defaults.
package crc_arb_pkg;

    localparam int DATA_W_DEF      = 768;
    localparam int CRC_W_DEF       = 32;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping. Requires N >= 2.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = |req;
        j     = 0;
        // Scan farthest offset first so the closest requester overwrites.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[IW'(j)]) begin
                grant          = '0;
                grant[IW'(j)]  = 1'b1;
                idx            = IW'(j);
            end
        end
    end

endmodule

// File: rtl/crc_arbiter.sv
// Shares one CRC engine among NUM_REQ requesters with round-robin grants.
// Define CRC_ARB_TIMEOUT_EN to add a WAIT watchdog that answers with rsp_err=1.
module crc_arbiter
    import crc_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CRC_W       = CRC_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [CRC_W-1:0]                rsp_crc,
    output logic                            rsp_err,
    output logic                            crc_valid,
    output logic [DATA_W-1:0]               crc_data,
    input  logic [CRC_W-1:0]                crc_result,
    input  logic                            crc_done,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    logic [1:0]         state;
    logic [IW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               timed_out;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

`ifdef CRC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] wait_cnt;

    // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               wait_cnt <= '0;
        else if (state != WAIT) wait_cnt <= '0;
        else                    wait_cnt <= wait_cnt + 1'b1;
    end

    assign timed_out = (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_err <= 1'b0;
        end else if (state == WAIT) begin
            if (crc_done)       rsp_err <= 1'b0;
            else if (timed_out) rsp_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timed_out      = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            crc_data <= '0;
            rsp_crc  <= '0;
        end else begin
            case (state)
                IDLE: if (arb_any) begin
                    crc_data <= req_data[arb_idx];
                    grant_id <= arb_idx;
                    state    <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (crc_done) begin
                        rsp_crc <= crc_result;
                        state   <= RESP;
                    end else if (timed_out) begin
                        rsp_crc <= '0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // req_ready is combinational; gate it so reset silences it immediately.
    assign req_ready = (state == IDLE && rst) ? arb_grant : '0;
    assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
    assign crc_valid = (state == ISSUE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_crc_arbiter.sv
// Scoreboard bench for crc_arbiter: random requesters, a CRC-32 engine model and a monitor.
module tb_crc_arbiter;

    localparam int N  = 4;
    localparam int DW = 768;
    localparam int CW = 32;
    localparam int TO = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [N-1:0]          req_valid = '0;
    logic [N-1:0][DW-1:0]  req_data = '0;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          rsp_valid;
    logic [CW-1:0]         rsp_crc;
    logic                  rsp_err;
    logic                  crc_valid;
    logic [DW-1:0]         crc_data;
    logic [CW-1:0]         crc_result = '0;
    logic                  crc_done = 1'b0;
    logic                  busy;
    logic [1:0]            grant_id;

    always #5 clk = ~clk;

    crc_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CRC_W(CW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_crc(rsp_crc), .rsp_err(rsp_err),
        .crc_valid(crc_valid), .crc_data(crc_data), .crc_result(crc_result),
        .crc_done(crc_done), .busy(busy), .grant_id(grant_id)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Plain MSB-first CRC-32 over the whole payload; this is what the engine returns.
    function automatic logic [CW-1:0] crc32(input logic [DW-1:0] d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
        end
        return ~c;
    endfunction

    // Engine model: latches the payload on crc_valid and answers 0..4 cycles later.
    logic          eng_hold = 1'b0;
    logic          spur = 1'b0;
    logic          eng_pend = 1'b0;
    int            eng_cnt = 0;
    logic [DW-1:0] eng_dat = '0;

    always begin
        @(negedge clk);
        if (!rst) eng_pend = 1'b0;
        else if (crc_valid && !eng_hold) begin
            eng_pend = 1'b1;
            eng_cnt  = $urandom_range(0, 4);
            eng_dat  = crc_data;
        end
        @(posedge clk);
        #2;
        crc_done   = spur;
        crc_result = $urandom;
        if (eng_pend) begin
            if (eng_cnt == 0) begin
                crc_done   = 1'b1;
                crc_result = crc32(eng_dat);
                eng_pend   = 1'b0;
            end else begin
                eng_cnt--;
            end
        end
    end

    typedef struct {
        int            id;
        logic [CW-1:0] crc;
        logic          err;
    } exp_t;

    exp_t          q[$];
    int            glog[$];
    logic          m_busy = 1'b0;
    int            m_ptr = 0;
    logic          exp_issue = 1'b0;
    logic [DW-1:0] exp_dat = '0;
    int            exp_gid = 0;
    logic [CW-1:0] last_crc = '0;
    logic          last_err = 1'b0;
    logic [N-1:0]  acc_mask = '0;
    int            busy_cyc = 0;
    int            cyc = 0;
    int            issue_cyc = 0;

    // Monitor: predicts grants from the round-robin rule and checks every output each cycle.
    always @(negedge clk) begin
        logic [N-1:0]  pred;
        int            g;
        exp_t          e;
        logic [CW-1:0] ec;
        cyc++;
        acc_mask = '0;
        pred     = '0;
        g        = -1;
        if (!rst) begin
            q.delete();
            m_busy = 1'b0; m_ptr = 0; exp_issue = 1'b0; busy_cyc = 0;
            last_crc = '0; last_err = 1'b0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_crc_valid", crc_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_crc_data", crc_data, 0);
            chk("rst_rsp_crc", rsp_crc, 0);
            chk("rst_rsp_err", rsp_err, 0);
        end else begin
            if (!m_busy)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) pred[g] = 1'b1;

            chk("busy", busy, m_busy);
            chk("crc_valid", crc_valid, exp_issue);
            if (exp_issue) issue_cyc = cyc;
            if (m_busy) begin
                chk("crc_data", crc_data, exp_dat);
                chk("grant_id", grant_id, exp_gid);
            end
            exp_issue = 1'b0;
            chk("req_ready", req_ready, pred);

            if (g >= 0) begin
                m_busy    = 1'b1;
                m_ptr     = (g + 1) % N;
                exp_issue = 1'b1;
                exp_dat   = req_data[g];
                exp_gid   = g;
                acc_mask  = pred;
                glog.push_back(g);
                ec = eng_hold ? '0 : crc32(req_data[g]);
                q.push_back('{g, ec, eng_hold});
            end

            if (rsp_valid != 0) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", rsp_valid, N'(1) << e.id);
                    chk("rsp_crc", rsp_crc, e.crc);
                    chk("rsp_err", rsp_err, e.err);
                    if (e.err) chk("timeout_latency", cyc - issue_cyc, TO + 1);
                    last_crc = e.crc;
                    last_err = e.err;
                end
                m_busy   = 1'b0;
                busy_cyc = 0;
            end else begin
                chk("rsp_crc_hold", rsp_crc, last_crc);
                chk("rsp_err_hold", rsp_err, last_err);
            end

            if (m_busy) busy_cyc++;
            if (busy_cyc > 200) begin
                chk("rsp_liveness", busy_cyc, 0);
                m_busy = 1'b0; busy_cyc = 0; q.delete();
            end
        end
    end

    // Stimulus: requesters hold until accepted; mode 1 random, mode 2 keep auto_mask busy.
    int           mode = 0;
    logic [N-1:0] auto_mask = '0;

    task automatic rnd_data(output logic [DW-1:0] d);
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    endtask

    task automatic step();
        logic [DW-1:0] d;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && ((mode == 1 && $urandom_range(0, 3) == 0) ||
                                  (mode == 2 && auto_mask[i]))) begin
                rnd_data(d);
                req_valid[i] = 1'b1;
                req_data[i]  = d;
            end
        end
    endtask

    task automatic raise(input int i);
        logic [DW-1:0] d;
        rnd_data(d);
        req_valid[i] = 1'b1;
        req_data[i]  = d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((m_busy || req_valid != 0) && n < 400);
        if (n >= 400) chk("idle_wait", n, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        req_valid = '0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic chk_order(input string nm, input int k, input int exp);
        chk(nm, (glog.size() > k) ? glog[k] : -1, exp);
    endtask

    initial begin
        logic [DW-1:0] p;
        repeat (3) step();
        rst = 1'b1;

        // Single fixed-pattern request from requester 0.
        step();
        p = {12{64'h0123_4567_89AB_6978}};
        req_valid[0] = 1'b1;
        req_data[0]  = p;
        wait_idle();

        // Spurious done while idle must not start anything.
        step(); spur = 1'b1;
        step(); spur = 1'b0;
        repeat (3) step();
        chk("spur_busy", busy, 0);
        chk("spur_rsp", rsp_valid, 0);

        // Everyone requesting: strict rotation from 0.
        do_reset();
        glog.delete();
        mode = 2; auto_mask = '1;
        repeat (25) step();
        mode = 0;
        wait_idle();
        for (int k = 0; k < 5; k++) chk_order("rotate", k, k % N);

        // After a grant to 2, requester 3 goes before 1.
        do_reset();
        glog.delete();
        step(); raise(2);
        wait_idle();
        raise(1); raise(3);
        wait_idle();
        chk_order("after2_first", 0, 2);
        chk_order("after2_next", 1, 3);
        chk_order("after2_last", 2, 1);

        // Reset while waiting on the engine; the pointer restarts at 0.
        eng_hold = 1'b1;
        step(); raise(1);
        repeat (5) step();
        chk("wait_busy", busy, 1);
        do_reset();
        eng_hold = 1'b0;
        glog.delete();
        step(); raise(2); raise(0);
        wait_idle();
        chk_order("post_rst_first", 0, 0);
        chk_order("post_rst_next", 1, 2);

`ifdef CRC_ARB_TIMEOUT_EN
        // Engine never answers: timeout response, then a late done is ignored.
        eng_hold = 1'b1;
        step(); raise(3);
        wait_idle();
        eng_hold = 1'b0;
        step(); spur = 1'b1;
        step(); spur = 1'b0;
        repeat (3) step();
        chk("late_done_busy", busy, 0);
`endif

        mode = 1;
        repeat (3000) step();
        mode = 0;
        wait_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
